seq_slice_comparator: RTL and testbench
=======================================

// Module: seq_slice_comparator
// PURPOSE
//   Multi-cycle unsigned magnitude comparator for two WIDTH-bit operands.
//   Processes SLICE bits per clock, starting with the MSB slice.
//   Carries the lt/eq cascade between slices in registers, using one
//   compare_slice instance instead of an unrolled chain.
//   Start/busy/done handshake. Used where area matters more than latency.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be a multiple of SLICE
//   SLICE   2   bits compared per cycle; NSLICE = WIDTH/SLICE, NSLICE >= 1
// PORTS
//   clk    in   1      sole clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only when busy=0
//   A      in   WIDTH  operand A, captured on an accepted start
//   B      in   WIDTH  operand B, captured on an accepted start
//   busy   out  1      high while a comparison is in RUN
//   done   out  1      one-cycle pulse: result is valid
//   EQ     out  1      A == B
//   LT     out  1      A <  B (unsigned)
//   GT     out  1      A >  B (unsigned)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; busy=done=EQ=LT=GT=0; counter=0.
//   States: IDLE -> RUN on start; RUN -> DONE after the last slice; DONE -> IDLE,
//     or DONE -> RUN if start is high in DONE (back-to-back).
//   Accept (edge 0): A/B copied into shift registers; eq_r=1, lt_r=0, cnt=0.
//   RUN cycle k (k=1..NSLICE): compare the top SLICE bits of the shift regs.
//     lt_r <= lt_r | (eq_r & (a_s < b_s)); eq_r <= eq_r & (a_s == b_s).
//     Shift both regs left by SLICE; cnt++.
//   Latency: done is high in cycle NSLICE+1 after the accept edge (5 for defaults).
//   Results: EQ=eq_r, LT=lt_r, GT=~eq_r&~lt_r. Registered when entering DONE.
//     Exactly one of EQ/LT/GT is 1. Held until the next accepted start or reset.
//     Cleared to 0 when the next comparison is accepted.
//   busy=1 only in RUN. start while busy=1 is ignored; operands are not re-sampled.
//   done is a single-cycle pulse and never stays high for two consecutive cycles.
//   NSLICE=1: RUN lasts one cycle.
//   Counter width: $clog2(NSLICE)+1. It does not wrap, because RUN exits at cnt==NSLICE-1.
//   Reset mid-RUN aborts the comparison with no done pulse.
// CONFIGURATION
//   `EARLY_EXIT_EN defined:
//     RUN -> DONE in the first cycle where eq_next==0 (the result is already decided).
//     Latency varies from 2 to NSLICE+1 cycles. Equal operands always take NSLICE+1.
//   Not defined:
//     Fixed latency of NSLICE+1 cycles for all inputs. Results are identical in both builds.
// STRUCTURE
//   cmp_pkg (shared include/package): state encodings
//     S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; parameter-legality check macro.
//   Sub-module compare_slice #(SLICE):
//     combinational; inputs a, b, lt_in, eq_in; outputs lt_out, eq_out.
//     This is the cascade cell, parametrised in width, reused by later blocks.
//   Top level: FSM, counter, two shift registers, result registers.
// TESTING (WIDTH=8, SLICE=2; cycle counts from the accept edge)
//   1. A=8'hA5, B=8'hA5, start 1 cycle -> done in cycle 5; EQ=1, LT=0, GT=0; busy=1 in cycles 1-4.
//   2. A=8'h3F, B=8'h40 -> LT=1. done in cycle 5; with EARLY_EXIT_EN, done in cycle 2.
//   3. A=8'hFF, B=8'hFE -> GT=1 (decided by the last slice); done in cycle 5 in both builds.
//   4. Start with 8'h10/8'h20, then start in cycle 2 with 8'h20/8'h10
//      -> second start ignored; LT=1 in cycle 5.
//   5. rst pulsed in cycle 2 -> busy/EQ/LT/GT=0 immediately, no done pulse.
//      A later start with 8'h01/8'h00 -> GT=1.
//   6. start held high through done -> back-to-back run; results cleared in
//      cycle 6; second done in cycle 10.

Source files
------------

// File: rtl/seq_slice_comparator_pkg.sv
// Shared definitions for the sequential slice comparator: FSM state encodings
// and a parameter-legality check usable inside a module body.
package seq_slice_comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// Elaboration-time guard: WIDTH must be a non-zero multiple of SLICE.
`ifndef CMP_PARAM_CHECK
`define CMP_PARAM_CHECK(W, S) \
    if ((S) < 1 || (W) < (S) || ((W) % (S)) != 0) begin : g_param_err \
        $error("seq_slice_comparator: WIDTH must be a non-zero multiple of SLICE"); \
    end
`endif

// File: rtl/seq_slice_comparator_slice.sv
// compare_slice: one cell of an MSB-first unsigned magnitude cascade.
// Combinational; folds one SLICE-bit chunk into the running lt/eq state.
module compare_slice
    import seq_slice_comparator_pkg::*;
#(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             lt_in,
    input  logic             eq_in,
    output logic             lt_out,
    output logic             eq_out
);

    // A lower slice can only decide the result while all higher slices matched.
    assign lt_out = lt_in | (eq_in & (a < b));
    assign eq_out = eq_in & (a == b);

endmodule

// File: rtl/seq_slice_comparator.sv
// seq_slice_comparator: multi-cycle unsigned A/B comparator, SLICE bits per
// clock, MSB slice first, using a single compare_slice cell.
// Optional feature macro: EARLY_EXIT_EN -- leave RUN as soon as the slices
// compared so far already differ (results are identical either way).
module seq_slice_comparator
    import seq_slice_comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             LT,
    output logic             GT
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = $clog2(NSLICE) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    `CMP_PARAM_CHECK(WIDTH, SLICE)

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sr, b_sr;
    logic [CNT_W-1:0]   cnt;
    logic               eq_r, lt_r;
    logic               eq_nxt, lt_nxt;
    logic               accept, finish;

    // Cascade cell sees the current top slice of both shift registers.
    compare_slice #(.SLICE(SLICE)) u_slice (
        .a      (a_sr[WIDTH-1 -: SLICE]),
        .b      (b_sr[WIDTH-1 -: SLICE]),
        .lt_in  (lt_r),
        .eq_in  (eq_r),
        .lt_out (lt_nxt),
        .eq_out (eq_nxt)
    );

    // start is only honoured outside RUN; DONE accepts it for back-to-back use.
    assign accept = start && (state != S_RUN);

`ifdef EARLY_EXIT_EN
    assign finish = (state == S_RUN) && ((cnt == LAST) || !eq_nxt);
`else
    assign finish = (state == S_RUN) && (cnt == LAST);
`endif

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; DONE always leaves after one cycle, so done is a pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, slice shifting, cascade state and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            cnt  <= '0;
            eq_r <= 1'b0;
            lt_r <= 1'b0;
            EQ   <= 1'b0;
            LT   <= 1'b0;
            GT   <= 1'b0;
        end else if (accept) begin
            a_sr <= A;
            b_sr <= B;
            cnt  <= '0;
            eq_r <= 1'b1;
            lt_r <= 1'b0;
            EQ   <= 1'b0;
            LT   <= 1'b0;
            GT   <= 1'b0;
        end else if (state == S_RUN) begin
            a_sr <= a_sr << SLICE;
            b_sr <= b_sr << SLICE;
            cnt  <= cnt + CNT_W'(1);
            eq_r <= eq_nxt;
            lt_r <= lt_nxt;
            if (finish) begin
                EQ <= eq_nxt;
                LT <= lt_nxt;
                GT <= ~eq_nxt & ~lt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Self-checking bench for seq_slice_comparator (WIDTH=8, SLICE=2).
// Cycle n is the clock period that ends with rising edge n; the accepting
// edge is edge 0, so cycle 1 is the first RUN cycle. Outputs are sampled on
// the falling edge. Honours EARLY_EXIT_EN for expected latency.
module tb_seq_slice_comparator;

    localparam int WIDTH = 8;
    localparam int SLICE = 2;
    localparam int NS    = WIDTH / SLICE;
`ifdef EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             busy, done, EQ, LT, GT;

    int n_cmp = 0;
    int n_err = 0;

    seq_slice_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .EQ    (EQ),
        .LT    (LT),
        .GT    (GT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {EQ,LT,GT} from plain unsigned arithmetic.
    function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {a == b, a < b, a > b};
    endfunction

    // Expected done cycle: NS+1, or one past the first differing slice with early exit.
    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat = NS + 1;
        if (EARLY) begin
            for (int k = NS - 1; k >= 0; k--) begin
                if ((a >> (k * SLICE)) != (b >> (k * SLICE))) begin
                    lat = (NS - k) + 1;
                    break;
                end
            end
        end
        return lat;
    endfunction

    // One comparison; optionally fire an ignored start with other operands in cycle intr.
    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int intr, input logic [WIDTH-1:0] a2,
                       input logic [WIDTH-1:0] b2, input string tag);
        int got = 0;
        int c = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (got == 0 && c < 20) begin
            c++;
            @(negedge clk);
            if (c == 1) check({tag, ".cleared"}, {29'd0, EQ, LT, GT}, 32'd0);
            if (done) got = c;
            else check({tag, ".busy"}, {31'd0, busy}, 32'd1);
            if (c == intr && !done) begin
                A = a2; B = b2; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        check({tag, ".lat"}, got, exp_lat(a, b));
        check({tag, ".res"}, {29'd0, EQ, LT, GT}, {29'd0, exp_res(a, b)});
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".hold"}, {29'd0, EQ, LT, GT}, {29'd0, exp_res(a, b)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int seen;
        int c;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        check("reset", {27'd0, busy, done, EQ, LT, GT}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run(8'hA5, 8'hA5, 0, 8'h00, 8'h00, "t1_eq");
        run(8'h3F, 8'h40, 0, 8'h00, 8'h00, "t2_lt");
        run(8'hFF, 8'hFE, 0, 8'h00, 8'h00, "t3_gt");
        run(8'h10, 8'h20, 2, 8'h20, 8'h10, "t4_ign");

        // Reset in cycle 2 aborts with no done pulse.
        @(negedge clk);
        A = 8'h10; B = 8'h20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst", {27'd0, busy, done, EQ, LT, GT}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("t5_nodone", seen, 0);
        run(8'h01, 8'h00, 0, 8'h00, 8'h00, "t5_after");

        // Back-to-back: start held through done.
        @(negedge clk);
        A = 8'h5A; B = 8'h5A; start = 1'b1;
        @(posedge clk);
        for (c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c < 5) check("t6_d1_wait", {31'd0, done}, 32'd0);
        end
        check("t6_d1", {28'd0, done, EQ, LT, GT}, {28'd0, 1'b1, exp_res(8'h5A, 8'h5A)});
        A = 8'h12; B = 8'h34;
        @(negedge clk);
        check("t6_c6", {27'd0, busy, done, EQ, LT, GT}, 32'h10);
        start = 1'b0;
        c = 6;
        while (!done && c < 30) begin
            @(negedge clk);
            c++;
        end
        check("t6_d2_lat", c, 5 + exp_lat(8'h12, 8'h34));
        check("t6_d2_res", {29'd0, EQ, LT, GT}, {29'd0, exp_res(8'h12, 8'h34)});

        // Randomized operands, biased toward equal / near-equal pairs.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: ;
            endcase
            run(ra, rb, ($urandom_range(0, 1) != 0) ? 1 : 0, rb, ra, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
